// File: rtl/forward_ctrl_pkg.sv
// forward_ctrl_pkg: forwarding encodings, opcodes and the select helper shared by decode and execute
package forward_ctrl_pkg;

   localparam logic [1:0] NO_FORWARD        = 2'b00;
   localparam logic [1:0] ONE_CYCLE_FORWARD = 2'b01;
   localparam logic [1:0] TWO_CYCLE_FORWARD = 2'b10;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_CSR    = 7'b1110011;

   // Youngest producer first: execute beats writeback when both match.
   function automatic logic [1:0] fwd_select(input logic used, input logic [4:0] rs,
                                             input logic x_we, input logic [4:0] x_rd,
                                             input logic w_we, input logic [4:0] w_rd);
      return (!used || rs == 5'd0)   ? NO_FORWARD :
             (x_we && rs == x_rd)    ? ONE_CYCLE_FORWARD :
             (w_we && rs == w_rd)    ? TWO_CYCLE_FORWARD : NO_FORWARD;
   endfunction

endpackage

// File: rtl/forward_ctrl_if.sv
// forward_ctrl_if: decode-side controls and execute-side forwarding selects
interface forward_ctrl_if;
   import forward_ctrl_pkg::*;

   logic        stall;
   logic        flush;
   logic [31:0] id_instruction;
   logic [1:0]  a_forward_select;
   logic [1:0]  b_forward_select;
   logic [4:0]  x_rd;
   logic [4:0]  w_rd;

   modport master (
      output stall, flush, id_instruction,
      input  a_forward_select, b_forward_select, x_rd, w_rd
   );

   modport slave (
      input  stall, flush, id_instruction,
      output a_forward_select, b_forward_select, x_rd, w_rd
   );

endinterface

// File: rtl/forward_ctrl_reg_usage_decode.sv
// reg_usage_decode: which source registers an instruction reads and whether it writes rd
module reg_usage_decode
   import forward_ctrl_pkg::*;
(
   input  logic [31:0] i_instruction,
   output logic        o_rs1_used,
   output logic        o_rs2_used,
   output logic        o_rd_we,
   output logic [4:0]  o_rs1,
   output logic [4:0]  o_rs2,
   output logic [4:0]  o_rd
);

   logic [6:0] w_opc;

   assign w_opc = i_instruction[6:0];
   assign o_rs1 = i_instruction[19:15];
   assign o_rs2 = i_instruction[24:20];
   assign o_rd  = i_instruction[11:7];

   // Classify by opcode; immediate CSR forms (funct3[2]=1) carry a uimm in the rs1 field.
   always_comb begin
      o_rd_we    = (w_opc == OPC_LUI || w_opc == OPC_AUIPC || w_opc == OPC_JAL ||
                    w_opc == OPC_JALR || w_opc == OPC_LOAD || w_opc == OPC_OP_IMM ||
                    w_opc == OPC_OP || w_opc == OPC_CSR) && (o_rd != 5'd0);
      o_rs1_used = w_opc == OPC_JALR || w_opc == OPC_BRANCH || w_opc == OPC_LOAD ||
                   w_opc == OPC_STORE || w_opc == OPC_OP_IMM || w_opc == OPC_OP ||
                   (w_opc == OPC_CSR && !i_instruction[14]);
      o_rs2_used = w_opc == OPC_BRANCH || w_opc == OPC_STORE || w_opc == OPC_OP;
   end

endmodule

// File: rtl/forward_ctrl.sv
// forward_ctrl: tracks execute/writeback destinations and registers operand forwarding selects
module forward_ctrl
   import forward_ctrl_pkg::*;
(
   input  logic           clk,
   input  logic           rst,
   forward_ctrl_if.slave  bus
);

   logic       w_rs1_used;
   logic       w_rs2_used;
   logic       w_rd_we;
   logic [4:0] w_rs1;
   logic [4:0] w_rs2;
   logic [4:0] w_id_rd;
   logic [1:0] w_a_sel;
   logic [1:0] w_b_sel;

   logic [4:0] r_x_rd;
   logic       r_x_we;
   logic [4:0] r_w_rd;
   logic       r_w_we;
   logic [1:0] r_a_sel;
   logic [1:0] r_b_sel;

   reg_usage_decode u_decode (
      .i_instruction (bus.id_instruction),
      .o_rs1_used    (w_rs1_used),
      .o_rs2_used    (w_rs2_used),
      .o_rd_we       (w_rd_we),
      .o_rs1         (w_rs1),
      .o_rs2         (w_rs2),
      .o_rd          (w_id_rd)
   );

   // Compare the decoding instruction's sources against the two older destinations.
   always_comb begin
      w_a_sel = fwd_select(w_rs1_used, w_rs1, r_x_we, r_x_rd, r_w_we, r_w_rd);
      w_b_sel = fwd_select(w_rs2_used, w_rs2, r_x_we, r_x_rd, r_w_we, r_w_rd);
   end

   // Advance the destination history; a flushed slot enters execute as a non-writing bubble.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_x_rd  <= 5'd0;
         r_x_we  <= 1'b0;
         r_w_rd  <= 5'd0;
         r_w_we  <= 1'b0;
         r_a_sel <= NO_FORWARD;
         r_b_sel <= NO_FORWARD;
      end else if (!bus.stall) begin
         r_w_rd  <= r_x_rd;
         r_w_we  <= r_x_we;
         r_x_rd  <= bus.flush ? 5'd0 : w_id_rd;
         r_x_we  <= bus.flush ? 1'b0 : w_rd_we;
         r_a_sel <= bus.flush ? NO_FORWARD : w_a_sel;
         r_b_sel <= bus.flush ? NO_FORWARD : w_b_sel;
      end
   end

   assign bus.a_forward_select = r_a_sel;
   assign bus.b_forward_select = r_b_sel;
   assign bus.x_rd             = r_x_rd;
   assign bus.w_rd             = r_w_rd;

endmodule

// File: tb/tb_forward_ctrl.sv
// tb_forward_ctrl: scoreboard bench for forward_ctrl with directed pipeline cases and random traffic
module tb_forward_ctrl;
   import forward_ctrl_pkg::*;

   typedef struct packed {
      logic [1:0] a;
      logic [1:0] b;
      logic [4:0] xrd;
      logic [4:0] wrd;
   } exp_t;

   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_errors = 0;
   exp_t sb[$];

   logic [4:0] m_xrd, m_wrd;
   logic       m_xwe, m_wwe;
   logic [1:0] m_a, m_b;

   localparam logic [31:0] NOP = 32'h0000_0013;

   always #5 clk = ~clk;

   forward_ctrl_if bus();

   forward_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
      end
   endtask

   function automatic logic [31:0] addi(input logic [4:0] rd, input logic [4:0] rs1, input logic [11:0] imm);
      return {imm, rs1, 3'b000, rd, 7'h13};
   endfunction

   function automatic logic [31:0] add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'h00, rs2, rs1, 3'b000, rd, 7'h33};
   endfunction

   function automatic logic [31:0] sub(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
      return {7'h20, rs2, rs1, 3'b000, rd, 7'h33};
   endfunction

   // Bench-side usage table: {reads rs1, reads rs2, writes rd}.
   function automatic logic [2:0] uses(input logic [31:0] ins);
      logic [2:0] u;
      case (ins[6:0])
         7'h37, 7'h17, 7'h6f: u = 3'b001;
         7'h67, 7'h03, 7'h13: u = 3'b101;
         7'h63, 7'h23:        u = 3'b110;
         7'h33:               u = 3'b111;
         7'h73:               u = ins[14] ? 3'b001 : 3'b101;
         default:             u = 3'b000;
      endcase
      if (ins[11:7] == 5'd0) u[0] = 1'b0;
      return u;
   endfunction

   function automatic logic [1:0] pick(input logic used, input logic [4:0] rs);
      if (!used || rs == 5'd0) return 2'b00;
      if (m_xwe && m_xrd == rs) return 2'b01;
      if (m_wwe && m_wrd == rs) return 2'b10;
      return 2'b00;
   endfunction

   task automatic cycle(input logic r, input logic s, input logic f, input logic [31:0] ins);
      exp_t       e;
      logic [2:0] u;
      logic [1:0] na, nb;
      @(negedge clk);
      rst = r;
      bus.stall = s;
      bus.flush = f;
      bus.id_instruction = ins;
      if (r) begin
         {m_xrd, m_wrd, m_xwe, m_wwe, m_a, m_b} = '0;
      end else if (!s) begin
         u  = uses(ins);
         na = f ? 2'b00 : pick(u[2], ins[19:15]);
         nb = f ? 2'b00 : pick(u[1], ins[24:20]);
         m_wrd = m_xrd;
         m_wwe = m_xwe;
         m_xrd = f ? 5'd0 : ins[11:7];
         m_xwe = f ? 1'b0 : u[0];
         m_a = na;
         m_b = nb;
      end
      sb.push_back('{m_a, m_b, m_xrd, m_wrd});
      @(posedge clk);
      #1;
      e = sb.pop_front();
      check("a_sel", 32'(bus.a_forward_select), 32'(e.a));
      check("b_sel", 32'(bus.b_forward_select), 32'(e.b));
      check("x_rd",  32'(bus.x_rd), 32'(e.xrd));
      check("w_rd",  32'(bus.w_rd), 32'(e.wrd));
   endtask

   task automatic sel_is(input string tag, input logic [1:0] a, input logic [1:0] b);
      check({tag, "_a"}, 32'(bus.a_forward_select), 32'(a));
      check({tag, "_b"}, 32'(bus.b_forward_select), 32'(b));
   endtask

   initial begin
      logic [6:0]  opcs [10] = '{7'h37, 7'h17, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
      logic [31:0] ins;
      rst = 1'b1;
      bus.stall = 1'b0;
      bus.flush = 1'b0;
      bus.id_instruction = NOP;
      {m_xrd, m_wrd, m_xwe, m_wwe, m_a, m_b} = '0;

      cycle(1, 0, 0, add(5, 5, 5));
      cycle(1, 0, 0, NOP);
      sel_is("reset", 2'b00, 2'b00);
      check("reset_x_rd", 32'(bus.x_rd), 0);
      check("reset_w_rd", 32'(bus.w_rd), 0);

      cycle(0, 0, 0, addi(5, 0, 1));
      cycle(0, 0, 0, add(6, 5, 5));
      sel_is("one_cycle", 2'b01, 2'b01);

      cycle(0, 0, 0, addi(5, 0, 1));
      cycle(0, 0, 0, NOP);
      cycle(0, 0, 0, sub(7, 5, 0));
      sel_is("two_cycle", 2'b10, 2'b00);

      cycle(0, 0, 0, addi(5, 0, 1));
      cycle(0, 0, 0, addi(5, 0, 2));
      cycle(0, 0, 0, add(8, 5, 0));
      sel_is("youngest", 2'b01, 2'b00);

      cycle(0, 0, 0, addi(0, 0, 3));
      cycle(0, 0, 0, add(1, 0, 0));
      sel_is("x0", 2'b00, 2'b00);
      cycle(0, 0, 0, {20'h00001, 5'd9, 7'h37});
      cycle(0, 0, 0, {12'h000, 5'd9, 3'b000, 5'd1, 7'h6f});
      sel_is("lui_jal", 2'b00, 2'b00);
      cycle(0, 0, 0, addi(1, 0, 4));
      cycle(0, 0, 0, {12'h300, 5'd1, 3'b101, 5'd2, 7'h73});
      sel_is("csrrwi", 2'b00, 2'b00);

      cycle(0, 0, 0, addi(5, 0, 1));
      cycle(0, 0, 0, NOP);
      cycle(0, 0, 0, NOP);
      cycle(0, 0, 0, add(6, 5, 0));
      sel_is("three_old", 2'b00, 2'b00);

      cycle(0, 0, 0, addi(5, 0, 1));
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 0, add(6, 5, 5));
         check("stall_x_rd", 32'(bus.x_rd), 5);
      end
      cycle(0, 0, 0, add(6, 5, 5));
      sel_is("after_stall", 2'b01, 2'b01);

      cycle(0, 0, 0, addi(5, 0, 1));
      cycle(0, 1, 1, add(6, 5, 5));
      check("stall_flush_x_rd", 32'(bus.x_rd), 5);
      cycle(0, 0, 1, add(6, 5, 5));
      sel_is("flush", 2'b00, 2'b00);
      check("flush_w_rd", 32'(bus.w_rd), 5);
      cycle(0, 0, 0, add(7, 5, 0));
      sel_is("after_flush", 2'b10, 2'b00);

      cycle(0, 0, 0, addi(5, 0, 1));
      cycle(1, 1, 0, add(6, 5, 5));
      sel_is("rst_in_stall", 2'b00, 2'b00);
      cycle(0, 0, 0, add(6, 5, 5));
      sel_is("rst_clears_we", 2'b00, 2'b00);

      for (int i = 0; i < 400; i++) begin
         ins = $urandom;
         ins[6:0]   = opcs[$urandom_range(0, 9)];
         ins[11:7]  = 5'($urandom_range(0, 3));
         ins[19:15] = 5'($urandom_range(0, 3));
         ins[24:20] = 5'($urandom_range(0, 3));
         cycle($urandom_range(0, 49) == 0, $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0, ins);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/forward_ctrl.md
# forward_ctrl

Forwarding-select generator for the three-stage pipeline. It drives the `a_forward_select` and `b_forward_select` inputs of the execute stage. It tracks the destination registers of the instructions currently in execute and writeback. For each instruction leaving decode, it registers which operand source the execute stage must use in the following cycle: register file, the current writeback value, or the one-cycle-old writeback value.

## Interface
Parameters:
- none; encodings come from the shared package.

Ports:
- `clk`  in  1  — clock; all state updates on the rising edge.
- `rst`  in  1  — reset; synchronous, active-high.
- `stall`  in  1  — pipeline freeze; all state and outputs hold.
- `flush`  in  1  — the instruction in decode is squashed and enters execute as a bubble.
- `id_instruction`  in  32  — the instruction in decode, which enters execute at the next edge.
- `a_forward_select`  out  2  — registered select for execute operand A (rs1).
- `b_forward_select`  out  2  — registered select for execute operand B (rs2).
- `x_rd`  out  5  — destination of the instruction in execute (debug/trace).
- `w_rd`  out  5  — destination of the instruction in writeback (debug/trace).

## Operation
Encodings:
- `NO_FORWARD` = 2'b00
- `ONE_CYCLE_FORWARD` = 2'b01
- `TWO_CYCLE_FORWARD` = 2'b10
- 2'b11 is never driven.

Decode of `id_instruction` by opcode [6:0]:
- `rd_we`: set for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, CSR; cleared if rd = x0.
- `rs1_used`: set for JALR, BRANCH, LOAD, STORE, OP-IMM, OP, and CSR with funct3[2]=0. CSRRWI (funct3[2]=1) does not use rs1.
- `rs2_used`: set for BRANCH, STORE, OP.
- Unknown opcode: all three flags are 0.

State:
- (`x_rd`, `x_we`): destination of the instruction in execute.
- (`w_rd`, `w_we`): destination of the instruction in writeback.

Select for each operand (rs = rs1 [19:15] or rs2 [24:20]):
- If the operand is used, rs ≠ 0, `x_we`, and rs == `x_rd`: `ONE_CYCLE_FORWARD`. This priority rule makes the youngest producer win.
- Else if the operand is used, rs ≠ 0, `w_we`, and rs == `w_rd`: `TWO_CYCLE_FORWARD`.
- Else: `NO_FORWARD`.

Per rising edge, in priority order:
- `rst`: `x_we`=`w_we`=0, `x_rd`=`w_rd`=0, both selects=00.
- `stall` (with or without `flush`): hold everything.
- `flush`: `w` ← `x`; `x_we`←0, `x_rd`←0; both selects ← 00.
- Otherwise: `w` ← `x`; `x` ← (decoded rd, `rd_we`); selects ← the computed values.

## Timing
- Selects are registered and valid for the whole cycle in which the corresponding instruction is in execute. Latency is one cycle from decode.
- `ONE_CYCLE_FORWARD` is aligned with the execute stage's live `writeback` input. `TWO_CYCLE_FORWARD` is aligned with its internally registered copy of `writeback`.
- No combinational path from any input to any output.
- Back-to-back identical rd: the younger producer wins.
- An instruction three or more slots older is never forwarded; the register file supplies it.
- A load producer is forwarded like any other producer. The writeback value already carries load data, so no stall is generated here.
- Reset mid-stall: reset wins.
- Deasserting `stall` resumes with the held state unchanged.
- The execute stage's `old_writeback` register has no enable, so `stall` must only be asserted while `writeback` is held constant by the rest of the pipeline.

## Structure
- Shared package (existing defines header):
  - forwarding encodings `NO_FORWARD`, `ONE_CYCLE_FORWARD`, `TWO_CYCLE_FORWARD`, which are moved out of execute so both ends use one definition;
  - `OPC_*` opcode constants.
- One combinational sub-module, `reg_usage_decode`: instruction in; `rs1_used`, `rs2_used`, `rd_we`, rs1, rs2, rd out.
- The top level holds the two-entry destination history and the select registers.

## Test plan
- `addi x5,x0,1` then `add x6,x5,x5` → in the cycle `add` is in execute, A=01 and B=01.
- `addi x5,x0,1`, `nop`, `sub x7,x5,x0` → `sub` in execute: A=10, B=00.
- `addi x5,…`, `addi x5,…`, `add x8,x5,x0` → A=01, because the youngest producer wins.
- `addi x0,x0,3` then `add x1,x0,x0` → A=00, B=00. The same result holds for `lui x9` then `jal x1` and `csrrwi` after a write to x1, since none of them read a register.
- `addi x5`, then `add x6,x5,x5` with `stall` high for 3 cycles → selects and `x_rd`=5 hold. After release, the same selects apply to `add`.
- `addi x5` followed by `flush` on `add x6,x5,x5` → the bubble gives selects 00, and the next instruction reading x5 gets 10. Asserting `rst` at any point gives `x_we`=`w_we`=0 and selects 00 on the following cycle.
